// File: rtl/banda_pkg.sv
// Shared types for the banda (assembly-line) sequencer: state encoding and helpers.
package banda_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WORK     = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/banda_work_timer.sv
// Load/count timer with a terminal-count flag at CYC-1; used for WORK steps and WAIT_OUT timeout.
module banda_work_timer
  import banda_pkg::*;
#(
  parameter int CYC = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = cnt_width(CYC);
  localparam logic [W-1:0] LAST = W'(CYC - 1);

  logic [W-1:0] cnt;

  // Holds at LAST so a long enable never wraps back through the terminal count.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/banda_sequencer.sv
// Banda sequencer: SHIFT/WORK stepping of NUM_ST station occupancy bits with output handshake.
// Optional WAIT_OUT timeout flag enabled by defining BANDA_TIMEOUT_EN.
module banda_sequencer
  import banda_pkg::*;
#(
  parameter int NUM_ST   = 4,
  parameter int PROC_CYC = 3,
  parameter int CNT_W    = 8,
  parameter int TMO_CYC  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               item_out,
  output logic               shift_en,
  output logic [NUM_ST-1:0]  st_busy,
  output logic [NUM_ST-1:0]  occ,
  output logic [CNT_W-1:0]   done_cnt,
  output logic [STATE_W-1:0] state_o,
  output logic               timeout
);

  if (NUM_ST < 2 || PROC_CYC < 1 || TMO_CYC < 1) begin : g_param_chk
    $error("banda_sequencer: NUM_ST>=2, PROC_CYC>=1, TMO_CYC>=1 required");
  end

  state_t            state, state_nxt;
  logic              halt_pend;
  logic              work_done;
  logic [NUM_ST-1:0] occ_d;

  banda_work_timer #(.CYC(PROC_CYC)) u_work_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state != WORK),
    .en    (state == WORK),
    .tc    (work_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !halt) state_nxt = SHIFT;
      SHIFT:    state_nxt = WORK;
      WORK: begin
        if (work_done) begin
          if (halt_pend)                           state_nxt = IDLE;
          else if (occ[NUM_ST-1] && !out_ready)    state_nxt = WAIT_OUT;
          else                                     state_nxt = SHIFT;
        end
      end
      WAIT_OUT: if (out_ready) state_nxt = SHIFT;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == SHIFT);
    in_ready = in_valid && (state == SHIFT);
    item_out = occ[NUM_ST-1] && (state == SHIFT);
    st_busy  = occ & {NUM_ST{state == WORK}};
    state_o  = state;
  end

  // A halt seen while running is remembered until the line actually parks in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_pend <= 1'b0;
    end else if ((state != IDLE) && (state_nxt == IDLE)) begin
      halt_pend <= 1'b0;
    end else if (halt && (state != IDLE)) begin
      halt_pend <= 1'b1;
    end
  end

  assign occ_d = {occ[NUM_ST-2:0], in_valid};

  for (genvar i = 0; i < NUM_ST; i++) begin : g_station
    always_ff @(posedge clk) begin
      if (reset) begin
        occ[i] <= 1'b0;
      end else if (shift_en) begin
        occ[i] <= occ_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt <= '0;
    end else if (item_out) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

`ifdef BANDA_TIMEOUT_EN
  logic tmo_tc;

  banda_work_timer #(.CYC(TMO_CYC)) u_tmo_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state != WAIT_OUT),
    .en    (state == WAIT_OUT),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (tmo_tc) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_banda_sequencer.sv
// Directed bench for banda_sequencer (default build and BANDA_TIMEOUT_EN build).
module tb_banda_sequencer;
  import banda_pkg::*;

`ifdef BANDA_TIMEOUT_EN
  localparam logic TMO_ON = 1'b1;
`else
  localparam logic TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, halt, in_valid, out_ready;
  logic       in_ready, item_out, shift_en, timeout;
  logic [3:0] st_busy, occ;
  logic [7:0] done_cnt;
  logic [1:0] state_o;

  logic       in_ready2, item_out2, shift_en2, timeout2;
  logic [3:0] st_busy2, occ2;
  logic [1:0] done_cnt2;
  logic [1:0] state_o2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banda_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .item_out(item_out), .shift_en(shift_en), .st_busy(st_busy), .occ(occ),
    .done_cnt(done_cnt), .state_o(state_o), .timeout(timeout)
  );

  banda_sequencer #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .in_valid(in_valid), .in_ready(in_ready2), .out_ready(out_ready),
    .item_out(item_out2), .shift_en(shift_en2), .st_busy(st_busy2), .occ(occ2),
    .done_cnt(done_cnt2), .state_o(state_o2), .timeout(timeout2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_shift(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!shift_en && n < 8);
    chk(tag, shift_en, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_state", state_o, IDLE);
    chk("rst_occ", occ, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_shift", shift_en, 0);
    chk("rst_item", item_out, 0);
    chk("rst_tmo", timeout, 0);

    // Continuous flow: shift every 4 cycles, first part out on the 5th SHIFT.
    reset = 1'b0; start = 1'b1; in_valid = 1'b1;
    step();
    start = 1'b0;
    chk("flow_in_ready", in_ready, 1);
    for (int cyc = 0; cyc <= 16; cyc++) begin
      chk($sformatf("flow_shift_c%0d", cyc), shift_en, (cyc % 4) == 0);
      chk($sformatf("flow_item_c%0d", cyc), item_out, cyc == 16);
      if (cyc < 16) step();
    end
    step();
    chk("flow_state_work", state_o, WORK);
    chk("flow_done", done_cnt, 1);
    chk("flow_done_w2", done_cnt2, 1);
    chk("flow_busy", st_busy, 4'b1111);

    // Full line, downstream stalled: park in WAIT_OUT.
    out_ready = 1'b0;
    step(); step(); step();
    chk("stall_state", state_o, WAIT_OUT);
    chk("stall_busy", st_busy, 0);
    chk("stall_shift", shift_en, 0);
    repeat (15) step();
    chk("stall_state_w15", state_o, WAIT_OUT);
    chk("stall_shift_w15", shift_en, 0);
    chk("stall_tmo_w15", timeout, 0);
    step();
    chk("stall_tmo_w16", timeout, TMO_ON);
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    chk("release_shift", shift_en, 1);
    chk("release_item", item_out, 1);
    chk("release_in_ready", in_ready, 0);
    chk("release_tmo_sticky", timeout, TMO_ON);
    step();
    chk("release_done", done_cnt, 2);
    chk("release_done_w2", done_cnt2, 2);
    chk("release_occ", occ, 4'b1110);

    // Halt pulse mid-WORK: finish the step, then park with occupancy intact.
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
    chk("halt_still_work", state_o, WORK);
    step();
    chk("halt_idle", state_o, IDLE);
    chk("halt_occ", occ, 4'b1110);
    step(); step();
    chk("halt_stay_idle", state_o, IDLE);
    chk("halt_no_shift", shift_en, 0);
    start = 1'b1; halt = 1'b1;
    step();
    chk("start_halt_idle", state_o, IDLE);
    halt = 1'b0;
    step();
    start = 1'b0;
    chk("restart_shift", state_o, SHIFT);
    chk("restart_item", item_out, 1);
    step();
    chk("restart_done", done_cnt, 3);
    chk("restart_done_w2", done_cnt2, 3);

    wait_shift("item4_shift");
    chk("item4_item", item_out, 1);
    wait_shift("item5_shift");
    chk("item5_item", item_out, 1);
    chk("item4_done_w2", done_cnt2, 0);
    in_valid = 1'b1;
    step();
    chk("item5_done", done_cnt, 5);
    chk("item5_done_w2", done_cnt2, 1);

    // Build occ = 1011 by shifting 1,0,1,1, then reset mid-WORK.
    wait_shift("fill_b2");
    chk("fill_b2_item", item_out, 0);
    in_valid = 1'b0;
    wait_shift("fill_b1");
    in_valid = 1'b1;
    wait_shift("fill_b0");
    in_valid = 1'b1;
    step();
    chk("fill_occ", occ, 4'b1011);
    chk("fill_busy", st_busy, 4'b1011);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_occ", occ, 0);
    chk("midrst_state", state_o, IDLE);
    chk("midrst_done", done_cnt, 0);
    chk("midrst_done_w2", done_cnt2, 0);
    chk("midrst_tmo", timeout, 0);

    // Empty line keeps cycling without producing parts.
    begin
      int pulses, shifts;
      pulses = 0; shifts = 0;
      in_valid = 1'b0; start = 1'b1;
      for (int k = 0; k < 12; k++) begin
        step();
        if (item_out) pulses++;
        if (shift_en) shifts++;
      end
      start = 1'b0;
      chk("empty_items", pulses, 0);
      chk("empty_shifts", shifts, 3);
      chk("empty_occ", occ, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
